// File: rtl/camera_pixel_packer.sv
// Packs camera pixels into 32-bit words and queues them in a first-word-fall-through FIFO.
// Define CAMERA_PACK_GRAY_EN to convert RGB565 to 8-bit luma and pack four pixels per word.
module camera_pixel_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_we,
  input  logic [7:0]                    pix_hi,
  input  logic [7:0]                    pix_lo,
  input  logic                          frame_ready,
  output logic                          out_valid,
  output logic [31:0]                   out_data,
  output logic                          out_sof,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic [15:0]                   frame_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

`ifdef CAMERA_PACK_GRAY_EN
  localparam int PW = 8;
  typedef enum logic [1:0] {P0, P1, P2, P3} state_t;
  localparam state_t FIRST = P0;
  localparam state_t LAST  = P3;
`else
  localparam int PW = 16;
  typedef enum logic {EMPTY, HALF} state_t;
  localparam state_t FIRST = EMPTY;
  localparam state_t LAST  = HALF;
`endif

  state_t         state;
  logic [31:0]    acc, word;
  logic [PW-1:0]  pix;
  logic           fr_q, fr_edge, push, push_ok, pop, sof_pend;
  logic [32:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wptr, rptr;

`ifdef CAMERA_PACK_GRAY_EN
  logic [15:0] rgb;
  logic [7:0]  r8, g8, b8;
  logic [9:0]  ysum;
  always_comb begin
    rgb  = {pix_hi, pix_lo};
    r8   = {rgb[15:11], rgb[15:13]};
    g8   = {rgb[10:5], rgb[10:9]};
    b8   = {rgb[4:0], rgb[4:2]};
    ysum = 10'(r8) + {1'b0, g8, 1'b0} + 10'(b8);
    pix  = ysum[9:2];
  end
`else
  assign pix = {pix_hi, pix_lo};
`endif

  assign fr_edge = frame_ready & ~fr_q;

  // A pixel arriving with the frame edge lands in its slot first; the flush then pushes the padded word.
  always_comb begin
    word = acc;
    push = 1'b0;
    if (pix_we) begin
      word[31 - int'(state)*PW -: PW] = pix;
      push = (state == LAST) || fr_edge;
    end else begin
      push = fr_edge && (state != FIRST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FIRST;
      acc   <= '0;
      fr_q  <= 1'b0;
    end else begin
      fr_q <= frame_ready;
      if (push) begin
        acc   <= '0;
        state <= FIRST;
      end else if (pix_we) begin
        acc   <= word;
        state <= state_t'(state + 1'b1);
      end
    end
  end

  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = push & ((fifo_level != FULL) | pop);
  assign out_data  = out_valid ? mem[rptr][31:0] : 32'h0;
  assign out_sof   = out_valid ? mem[rptr][32] : 1'b0;

  always_ff @(posedge clk)
    if (push_ok) mem[wptr] <= {sof_pend, word};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      frame_cnt  <= '0;
      sof_pend   <= 1'b1;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      fifo_level <= fifo_level + (AW+1)'(push_ok) - (AW+1)'(pop);
      if (push & ~push_ok) overflow <= 1'b1;
      else if (clr_ovf)    overflow <= 1'b0;
      // A dropped word leaves the start-of-frame marker for the next word that fits.
      if (fr_edge) begin
        frame_cnt <= frame_cnt + 16'd1;
        sof_pend  <= 1'b1;
      end else if (push_ok) begin
        sof_pend  <= 1'b0;
      end
    end
  end
endmodule

// File: doc/camera_pixel_packer.md
CAMERA_PIXEL_PACKER -- requirements
Module: camera_pixel_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, output word FIFO depth (power of two, 4..256).
REQ-002 SHALL have ports: clk  in  1  single clock for all logic (camera pixel clock domain).
REQ-003 SHALL have: reset  in  1  asynchronous, active-high.
REQ-004 SHALL have: pix_we  in  1  pixel strobe from capture stage; pixel valid when high at rising clk.
REQ-005 SHALL have: pix_hi  in  8  pixel high byte, RGB565 bits [15:8].
REQ-006 SHALL have: pix_lo  in  8  pixel low byte, RGB565 bits [7:0].
REQ-007 SHALL have: frame_ready  in  1  capture stage end-of-frame level; rising edge marks frame end.
REQ-008 SHALL have: out_valid  out  1  FIFO head word valid.
REQ-009 SHALL have: out_data  out  32  FIFO head word.
REQ-010 SHALL have: out_sof  out  1  head word is first word of a frame.
REQ-011 SHALL have: out_ready  in  1  downstream accepts head word.
REQ-012 SHALL have: fifo_level  out  log2(FIFO_DEPTH)+1  words stored.
REQ-013 SHALL have: overflow  out  1  sticky word-dropped flag.
REQ-014 SHALL have: clr_ovf  in  1  synchronous clear of overflow.
REQ-015 SHALL have: frame_cnt  out  16  completed frames.

Function
REQ-016 Pixel SHALL be {pix_hi,pix_lo}, sampled at rising clk when pix_we=1; pix_we=0 cycles ignored.
REQ-017 Packer FSM SHALL have states EMPTY (no pending pixel) and HALF (one pending); EMPTY->HALF on pixel, HALF->EMPTY on pixel with push.
REQ-018 Word SHALL be {first pixel, second pixel}: first in [31:16], second in [15:0].
REQ-019 Pushed word SHALL appear at out_data/out_valid the cycle after the push edge (first-word-fall-through, 1-cycle latency).
REQ-020 Pop SHALL occur at rising clk when out_valid=1 and out_ready=1; out_data undefined-but-stable when out_valid=0 is not required, value is don't-care.
REQ-021 frame_ready rising edge (registered edge detect, 1-cycle) in HALF SHALL push pending pixel zero-padded in [15:0] and go to EMPTY; in EMPTY no push.
REQ-022 pix_we coincident with detected frame_ready edge SHALL be packed first, then flush applied, both in current frame.
REQ-023 First word pushed after reset or after a frame end SHALL carry sof=1, stored in FIFO alongside data; all others sof=0.
REQ-024 frame_cnt SHALL increment on each detected frame_ready edge, wrapping 65535->0.
REQ-025 Push when full and no pop SHALL drop the word (sof flag not consumed) and set overflow; push+pop same cycle when full SHALL succeed.
REQ-026 Pop when empty SHALL be ignored; fifo_level never below 0 or above FIFO_DEPTH.
REQ-027 overflow SHALL stay set until clr_ovf=1; set and clear same cycle -> set wins.

Reset
REQ-028 reset SHALL immediately force: FSM EMPTY, FIFO empty, out_valid=0, out_sof=0, out_data=0, fifo_level=0, overflow=0, frame_cnt=0, sof-pending=1, edge detector=0.
REQ-029 reset mid-frame SHALL discard pending pixel and all FIFO contents; no partial word emitted after release.

Configuration
REQ-030 Macro CAMERA_PACK_GRAY_EN defined: each pixel SHALL convert to 8-bit Y = (r8 + 2*g8 + b8) >> 2 with r8={R,R[4:2]}, g8={G,G[5:4]}, b8={B,B[4:2]}, 10-bit sum, four pixels per word, first in [31:24]; FSM phases P0..P3; flush zero-pads unused low bytes.
REQ-031 Macro undefined: RGB565 two-pixel packing per REQ-017/018 only; no conversion logic present.

Verification
REQ-032 Pixels 0x1234, 0xABCD with out_ready=1 -> one word 0x1234ABCD, sof=1, valid one cycle after second pixel.
REQ-033 Three pixels 0x0001,0x0002,0x0003 then frame_ready rise -> words 0x00010002 (sof=1), 0x00030000 (sof=0); frame_cnt=1.
REQ-034 out_ready=0, 2*FIFO_DEPTH+2 pixels -> fifo_level=16, overflow=1; clr_ovf -> overflow=0; drain yields first 16 words in order.
REQ-035 Full FIFO, simultaneous push and pop -> level stays 16, overflow stays 0, new word at tail.
REQ-036 reset asserted in HALF with 3 words queued -> out_valid=0, level=0 immediately; next pixels 0x5555,0xAAAA -> 0x5555AAAA, sof=1.
REQ-037 CAMERA_PACK_GRAY_EN: pixels 0xFFFF,0x0000,0xF800,0x07E0 -> word 0xFF003F7F.
